qkv_frame_loader: RTL and testbench
===================================

Name: qkv_frame_loader

Overview:
- Producer side of the attention pipeline's matrix input interface: turns a token-serial stream into the flattened whole-frame Q/K/V buses that the Q*K^T stage consumes.
- Each input beat carries one token's Q, K and V rows (TOKEN_DIM elements each).
- After TOKEN_NUM beats, the loader presents one complete frame on the output buses, gated by a valid/ready handshake.
- Two ping-pong banks let the next frame load while the previous one waits for downstream.

Parameters:
- DATA_WIDTH, 16, bits per element (fp16 carried opaquely; no arithmetic on data).
- TOKEN_DIM, 4, elements per token row.
- TOKEN_NUM, 8, tokens per frame; must be >= 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  token beat valid.
- in_ready  out  1  loader can accept a beat.
- in_last  in  1  sender marks the final token of a frame.
- in_q  in  DATA_WIDTH*TOKEN_DIM  Q row; element c at [DATA_WIDTH*c +: DATA_WIDTH].
- in_k  in  DATA_WIDTH*TOKEN_DIM  K row; same layout as in_q.
- in_v  in  DATA_WIDTH*TOKEN_DIM  V row; same layout as in_q.
- out_valid  out  1  complete frame present.
- out_ready  in  1  downstream accepts the frame.
- Q_out  out  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  frame Q.
- K_out  out  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  frame K.
- V_out  out  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  frame V.
- len_err  out  1  sticky framing error.

Behaviour:
- Packing: token r, element c maps to [DATA_WIDTH*(r*TOKEN_DIM+c) +: DATA_WIDTH], row-major. Token r is the r-th accepted beat of the frame.
- State:
  - two banks, each with a full flag;
  - wr_bank, wr_idx (0..TOKEN_NUM-1);
  - rd_bank.
- Reset (rst=1 at an edge): all storage and flags cleared, wr_idx=0, wr_bank=rd_bank=0. Outputs then read out_valid=0, in_ready=1, Q/K/V_out=0, len_err=0.
- Reset mid-frame discards any partial or pending frame with no output handshake.
- in_ready = !full[wr_bank]. It is a function of registered state only, never of in_valid or out_ready.
- Input accept (in_valid & in_ready):
  - rows are written into wr_bank at wr_idx;
  - wr_idx increments;
  - when wr_idx==TOKEN_NUM-1: full[wr_bank] sets, wr_idx wraps to 0, wr_bank toggles.
- Framing check: len_err sets (sticky until rst) if in_last=1 on an accepted beat with wr_idx!=TOKEN_NUM-1, or in_last=0 on the beat with wr_idx==TOKEN_NUM-1. The frame still completes on count; in_last never truncates it.
- Output side:
  - out_valid = full[rd_bank];
  - Q/K/V_out drive rd_bank storage combinationally from registers (glitch-free, stable while out_valid=1 and not accepted).
  - On out_valid & out_ready: full[rd_bank] clears and rd_bank toggles.
  - Bank contents are not cleared on read; the outputs show the stale bank while out_valid=0, and downstream must ignore them.
- Latency: last beat accepted at edge t gives out_valid=1 from cycle t+1. Zero-bubble: with out_ready held high, frames stream back to back at one beat per cycle.
- Simultaneous events:
  - completing a frame into bank A and consuming bank B in the same cycle is legal; both flags update independently.
  - Full and free events never target the same bank in one cycle.
- Both banks full: in_ready=0 until the next output handshake. in_ready returns to 1 in the cycle after that handshake.
- Downstream hold: out_valid must not drop without a handshake.

Decomposition:
- Shared package (attn_pkg):
  - localparams ROW_W=DATA_WIDTH*TOKEN_DIM and FRAME_W=ROW_W*TOKEN_NUM;
  - IDX_W=$clog2(TOKEN_NUM);
  - a row-offset function used by both loader and consumers.
- One sub-module, qkv_frame_bank:
  - TOKEN_NUM×3 row registers with a row write-enable and index;
  - synchronous reset;
  - flattened Q/K/V read buses.
- Instantiated twice; the top holds the counters, flags and output mux.

Test Plan:
- Single frame, defaults: send tokens r=0..7 with element (r,c)=16'h0100+r*4+c, in_last on r=7.
  - out_valid rises the cycle after beat 7.
  - Q_out[15:0]=16'h0100 and Q_out[511:496]=16'h011F (element r=7,c=3); K and V checked likewise.
  - len_err=0.
- Streaming, out_ready=1, in_valid=1 continuously for 3 frames: in_ready never drops; three handshakes, 8 cycles apart, with correct per-frame data.
- Backpressure, out_ready=0: frames 1 and 2 load; in_ready drops after beat 16.
  - Pulse out_ready for 1 cycle: frame 1 delivered, in_ready=1 next cycle, out_valid stays 1 showing frame 2.
- Framing: in_last on beat 5 → len_err=1 from the next cycle; the frame still emits after beat 8. A subsequent good frame leaves len_err=1.
- Mid-frame reset: after 4 beats assert rst for 1 cycle → out_valid=0, in_ready=1. Next 8 beats form a frame whose row 0 equals the first post-reset beat.
- Stall gaps: in_valid toggled randomly over 8 beats → data order preserved; out_valid timing follows the last accepted beat.

Source files
------------

// File: rtl/attn_pkg.sv
// attn_pkg: shared geometry of the attention matrix interface.
package attn_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int TOKEN_DIM = 4;
    localparam int TOKEN_NUM = 8;
    localparam int ROW_W = DATA_WIDTH * TOKEN_DIM;
    localparam int FRAME_W = ROW_W * TOKEN_NUM;
    localparam int IDX_W = $clog2(TOKEN_NUM);
    function automatic int row_off(input int r, input int row_w);
        return r * row_w;
    endfunction
endpackage

// File: rtl/qkv_frame_bank.sv
// qkv_frame_bank: one frame of Q/K/V row registers with flattened read buses.
module qkv_frame_bank #(
    parameter int RW = 64,
    parameter int N = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [RW-1:0] q,
    input  logic [RW-1:0] k,
    input  logic [RW-1:0] v,
    output logic [N*RW-1:0] q_frame,
    output logic [N*RW-1:0] k_frame,
    output logic [N*RW-1:0] v_frame
);
    import attn_pkg::*;
    logic [N*RW-1:0] q_mem, k_mem, v_mem;
    always_ff @(posedge clk) begin
        if (rst) begin
            q_mem <= '0;
            k_mem <= '0;
            v_mem <= '0;
        end else if (we) begin
            q_mem[row_off(int'(idx), RW) +: RW] <= q;
            k_mem[row_off(int'(idx), RW) +: RW] <= k;
            v_mem[row_off(int'(idx), RW) +: RW] <= v;
        end
    end
    assign q_frame = q_mem;
    assign k_frame = k_mem;
    assign v_frame = v_mem;
endmodule

// File: rtl/qkv_frame_loader.sv
// qkv_frame_loader: token-serial Q/K/V rows into ping-pong whole-frame buses.
module qkv_frame_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int TOKEN_DIM = 4,
    parameter int TOKEN_NUM = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_last,
    input  logic [DATA_WIDTH*TOKEN_DIM-1:0] in_q,
    input  logic [DATA_WIDTH*TOKEN_DIM-1:0] in_k,
    input  logic [DATA_WIDTH*TOKEN_DIM-1:0] in_v,
    output logic out_valid,
    input  logic out_ready,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q_out,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K_out,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_out,
    output logic len_err
);
    import attn_pkg::*;
    localparam int RW = DATA_WIDTH * TOKEN_DIM;
    localparam int FW = RW * TOKEN_NUM;
    localparam int IW = $clog2(TOKEN_NUM);
    logic [1:0] full, set, clr;
    logic wr_bank, rd_bank, accept, take, last_beat;
    logic [IW-1:0] wr_idx;
    logic [FW-1:0] q_bank [2];
    logic [FW-1:0] k_bank [2];
    logic [FW-1:0] v_bank [2];
    assign in_ready = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign accept = in_valid && in_ready;
    assign take = out_valid && out_ready;
    assign last_beat = wr_idx == IW'(TOKEN_NUM - 1);
    assign set = (accept && last_beat) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr = take ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx <= '0;
            len_err <= 1'b0;
        end else begin
            full <= (full | set) & ~clr;
            if (take) rd_bank <= ~rd_bank;
            if (accept) begin
                wr_idx <= last_beat ? '0 : wr_idx + IW'(1);
                if (last_beat) wr_bank <= ~wr_bank;
                if (in_last != last_beat) len_err <= 1'b1;
            end
        end
    end
    for (genvar b = 0; b < 2; b++) begin : g_bank
        qkv_frame_bank #(.RW(RW), .N(TOKEN_NUM), .IW(IW)) u_bank (
            .clk(clk),
            .rst(rst),
            .we(accept && (wr_bank == 1'(b))),
            .idx(wr_idx),
            .q(in_q),
            .k(in_k),
            .v(in_v),
            .q_frame(q_bank[b]),
            .k_frame(k_bank[b]),
            .v_frame(v_bank[b])
        );
    end
    assign Q_out = rd_bank ? q_bank[1] : q_bank[0];
    assign K_out = rd_bank ? k_bank[1] : k_bank[0];
    assign V_out = rd_bank ? v_bank[1] : v_bank[0];
endmodule

// File: tb/tb_qkv_frame_loader.sv
// tb_qkv_frame_loader: frame-queue model checked every cycle plus literal spot checks.
module tb_qkv_frame_loader;
    import attn_pkg::*;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_last, out_valid, out_ready, len_err;
    logic [ROW_W-1:0] in_q, in_k, in_v;
    logic [FRAME_W-1:0] Q_out, K_out, V_out;
    int vectors = 0;
    int miscompares = 0;
    logic [FRAME_W-1:0] fq_q[$], fq_k[$], fq_v[$];
    logic [FRAME_W-1:0] cur_q, cur_k, cur_v;
    int cnt = 0;
    bit err = 0;
    qkv_frame_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_q(in_q), .in_k(in_k), .in_v(in_v), .out_valid(out_valid), .out_ready(out_ready),
        .Q_out(Q_out), .K_out(K_out), .V_out(V_out), .len_err(len_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [FRAME_W-1:0] a, input logic [FRAME_W-1:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    function automatic logic [15:0] el(input int f, input int m, input int r, input int c);
        return 16'(32'h0100 * (m + 1) + f * 32'h1000 + r * 4 + c);
    endfunction
    function automatic logic [ROW_W-1:0] row(input int f, input int m, input int r);
        logic [ROW_W-1:0] x;
        for (int c = 0; c < TOKEN_DIM; c++) x[DATA_WIDTH*c +: DATA_WIDTH] = el(f, m, r, c);
        return x;
    endfunction
    // Model: a frame becomes visible once TOKEN_NUM beats are in; at most two wait.
    always @(posedge clk) begin
        if (rst) begin
            fq_q.delete(); fq_k.delete(); fq_v.delete();
            cnt = 0;
            err = 0;
        end else begin
            bit acc, tk;
            acc = in_valid && fq_q.size() < 2;
            tk = out_ready && fq_q.size() > 0;
            if (tk) begin
                void'(fq_q.pop_front()); void'(fq_k.pop_front()); void'(fq_v.pop_front());
            end
            if (acc) begin
                cur_q[cnt*ROW_W +: ROW_W] = in_q;
                cur_k[cnt*ROW_W +: ROW_W] = in_k;
                cur_v[cnt*ROW_W +: ROW_W] = in_v;
                if (in_last != (cnt == TOKEN_NUM - 1)) err = 1;
                if (cnt == TOKEN_NUM - 1) begin
                    fq_q.push_back(cur_q); fq_k.push_back(cur_k); fq_v.push_back(cur_v);
                    cnt = 0;
                end else cnt++;
            end
        end
    end
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", FRAME_W'(in_ready), FRAME_W'(fq_q.size() < 2));
            chk("out_valid", FRAME_W'(out_valid), FRAME_W'(fq_q.size() > 0));
            chk("len_err", FRAME_W'(len_err), FRAME_W'(err));
            if (fq_q.size() > 0) begin
                chk("Q_out", Q_out, fq_q[0]);
                chk("K_out", K_out, fq_k[0]);
                chk("V_out", V_out, fq_v[0]);
            end
        end
    end
    task automatic beat(input int f, input int r, input bit last);
        in_valid = 1'b1;
        in_last = last;
        in_q = row(f, 0, r);
        in_k = row(f, 1, r);
        in_v = row(f, 2, r);
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL beat_timeout: frame %0d row %0d never accepted", f, r);
    endtask
    task automatic frame(input int f, input int bad, input bit keep, input bit gaps);
        for (int r = 0; r < TOKEN_NUM; r++) begin
            if (gaps && r > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            beat(f, r, bad < 0 ? (r == TOKEN_NUM - 1) : (r == bad));
        end
        if (!keep) in_valid = 1'b0;
    endtask
    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_q = '0; in_k = '0; in_v = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", FRAME_W'(out_valid), '0);
        chk("rst_in_ready", FRAME_W'(in_ready), FRAME_W'(1));
        chk("rst_Q_out", Q_out, '0);
        chk("rst_len_err", FRAME_W'(len_err), '0);
        frame(0, -1, 0, 0);
        chk("f0_valid", FRAME_W'(out_valid), FRAME_W'(1));
        chk("f0_q_first", FRAME_W'(Q_out[15:0]), FRAME_W'(16'h0100));
        chk("f0_q_last", FRAME_W'(Q_out[511:496]), FRAME_W'(16'h011F));
        chk("f0_k_last", FRAME_W'(K_out[511:496]), FRAME_W'(16'h021F));
        chk("f0_v_first", FRAME_W'(V_out[15:0]), FRAME_W'(16'h0300));
        chk("f0_len_err", FRAME_W'(len_err), '0);
        drain();
        chk("f0_consumed", FRAME_W'(out_valid), '0);
        out_ready = 1'b1;
        frame(1, -1, 1, 0);
        frame(2, -1, 1, 0);
        frame(3, -1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        frame(4, -1, 0, 0);
        frame(5, -1, 0, 0);
        chk("bp_in_ready", FRAME_W'(in_ready), '0);
        chk("bp_q4", FRAME_W'(Q_out[15:0]), FRAME_W'(16'h4100));
        drain();
        chk("bp_in_ready_back", FRAME_W'(in_ready), FRAME_W'(1));
        chk("bp_valid_held", FRAME_W'(out_valid), FRAME_W'(1));
        chk("bp_q5", FRAME_W'(Q_out[15:0]), FRAME_W'(16'h5100));
        drain();
        for (int r = 0; r < 5; r++) beat(6, r, r == 4);
        in_valid = 1'b0;
        chk("early_last_err", FRAME_W'(len_err), FRAME_W'(1));
        for (int r = 5; r < TOKEN_NUM; r++) beat(6, r, 1'b0);
        in_valid = 1'b0;
        chk("early_last_emits", FRAME_W'(out_valid), FRAME_W'(1));
        drain();
        frame(7, -1, 0, 0);
        chk("err_sticky", FRAME_W'(len_err), FRAME_W'(1));
        drain();
        for (int r = 0; r < 4; r++) beat(8, r, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", FRAME_W'(out_valid), '0);
        chk("mid_rst_ready", FRAME_W'(in_ready), FRAME_W'(1));
        chk("mid_rst_err", FRAME_W'(len_err), '0);
        chk("mid_rst_q", Q_out, '0);
        frame(9, -1, 0, 0);
        chk("post_rst_row0", FRAME_W'(Q_out[63:0]), FRAME_W'(64'h9103_9102_9101_9100));
        drain();
        frame(10, -1, 0, 1);
        chk("stall_last_row", FRAME_W'(V_out[511:448]), FRAME_W'(64'hA31F_A31E_A31D_A31C));
        drain();
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
